// File: rtl/dmem_responder_if.sv
// Load/store bus between the MEM stage and the data-memory responder.
// Latency: none (wires only).
// Backpressure: the responder holds stall_o high until the access completes.
interface dmem_responder_if;
  logic        Memory_read_i;
  logic        Memory_write_i;
  logic [31:0] address_i;
  logic [31:0] write_data_i;
  logic [31:0] read_data_o;
  logic        ack_o;
  logic        stall_o;
  logic        err_o;

  modport master (
    output Memory_read_i, Memory_write_i, address_i, write_data_i,
    input  read_data_o, ack_o, stall_o, err_o
  );

  modport slave (
    input  Memory_read_i, Memory_write_i, address_i, write_data_i,
    output read_data_o, ack_o, stall_o, err_o
  );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data memory that serves one MEM-stage load or store per transaction.
// Latency: ack_o asserts LATENCY cycles after acceptance; one transaction per LATENCY+1 cycles.
// Backpressure: stall_o freezes the pipeline from the request cycle until the ack cycle.
module dmem_responder #(
  parameter int DEPTH   = 32,
  parameter int LATENCY = 3
) (
  input logic              clk_i,
  input logic              rst_i,
  dmem_responder_if.slave  bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic          wr_q;
  logic          fault_q;
  logic [31:0]   rdata_q;
  logic [31:0]   mem [DEPTH];

  logic          req;
  logic          req_fault;
  logic [IW-1:0] req_idx;

  logic          commit;
  logic          c_wr;
  logic          c_fault;
  logic [IW-1:0] c_idx;
  logic [31:0]   c_data;

  assign req     = bus.Memory_read_i | bus.Memory_write_i;
  assign req_idx = bus.address_i[IW+1:2];

  assign req_fault = (|bus.address_i[1:0])
                   | (bus.address_i >= 32'(4 * DEPTH))
                   | (bus.Memory_read_i & bus.Memory_write_i);

  // The access commits on the edge that enters RESP; with LATENCY=1 that is
  // the acceptance edge itself, so the live inputs stand in for the captured ones.
  always_comb begin
    commit  = 1'b0;
    c_wr    = wr_q;
    c_fault = fault_q;
    c_idx   = idx_q;
    c_data  = wdata_q;
    if (state == IDLE && req && LATENCY == 1) begin
      commit  = 1'b1;
      c_wr    = bus.Memory_write_i;
      c_fault = req_fault;
      c_idx   = req_idx;
      c_data  = bus.write_data_i;
    end else if (state == WAIT && cnt == '0) begin
      commit  = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            idx_q   <= req_idx;
            wdata_q <= bus.write_data_i;
            wr_q    <= bus.Memory_write_i;
            fault_q <= req_fault;
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= CW'(LATENCY - 2);
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (commit && c_wr && !c_fault) begin
      mem[c_idx] <= c_data;
    end
  end

  // Load data is sticky: only a read ack or a fault ack replaces it.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rdata_q <= '0;
    end else if (commit) begin
      if (c_fault) begin
        rdata_q <= '0;
      end else if (!c_wr) begin
        rdata_q <= mem[c_idx];
      end
    end
  end

  assign bus.stall_o     = rst_i & ((state == IDLE && req) || state == WAIT);
  assign bus.ack_o       = (state == RESP);
  assign bus.err_o       = (state == RESP) & fault_q;
  assign bus.read_data_o = rdata_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one LATENCY=3 instance for most scenarios,
// plus a LATENCY=1 instance for the single-cycle timing case.
module tb_dmem_responder;
  logic clk;
  logic rst_i;
  int   n_cmp;
  int   n_bad;

  dmem_responder_if bus3 ();
  dmem_responder_if bus1 ();

  dmem_responder #(.DEPTH(32), .LATENCY(3)) u_dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus3.slave)
  );

  dmem_responder #(.DEPTH(32), .LATENCY(1)) u_dut1 (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear3();
    bus3.Memory_read_i  = 1'b0;
    bus3.Memory_write_i = 1'b0;
    bus3.address_i      = '0;
    bus3.write_data_i   = '0;
  endtask

  // Drives one request on bus3 (entered at posedge+1), holds it through the ack
  // cycle, and reports what was seen. Leaves at posedge+1 with inputs cleared.
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, output int n_stall, output int ack_at,
                         output logic err, output logic [31:0] rdata);
    bus3.Memory_read_i  = rd;
    bus3.Memory_write_i = wr;
    bus3.address_i      = addr;
    bus3.write_data_i   = data;
    n_stall = 0;
    ack_at  = -1;
    err     = 1'b0;
    rdata   = '0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (bus3.stall_o) n_stall++;
      if (bus3.ack_o) begin
        ack_at = c;
        err    = bus3.err_o;
        rdata  = bus3.read_data_o;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    clear3();
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    bus3.Memory_read_i  = 1'b0;
    bus3.Memory_write_i = 1'b1;
    bus3.address_i      = 32'h0;
    bus3.write_data_i   = 32'h1;
    bus1.Memory_read_i  = 1'b0;
    bus1.Memory_write_i = 1'b0;
    bus1.address_i      = '0;
    bus1.write_data_i   = '0;
    tick();
    tick();
    n_cmp++; if (bus3.stall_o !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", bus3.stall_o); end
    n_cmp++; if (bus3.ack_o !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b want 0", bus3.ack_o); end
    n_cmp++; if (bus3.err_o !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", bus3.err_o); end
    n_cmp++; if (bus3.read_data_o !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", bus3.read_data_o); end
    clear3();
    #2 rst_i = 1'b1;
    tick();
    for (int c = 0; c < 4; c++) begin
      n_cmp++; if (bus3.stall_o !== 1'b0 || bus3.ack_o !== 1'b0) begin
        n_bad++; $display("FAIL idle_quiet: stall %b ack %b want 0 0", bus3.stall_o, bus3.ack_o);
      end
      tick();
    end
  endtask

  task automatic test_mem_clear();
    int ns, at; logic e; logic [31:0] rd;
    for (int i = 0; i < 32; i++) begin
      run_txn(1'b1, 1'b0, 32'(4 * i), 32'h0, ns, at, e, rd);
      n_cmp++; if (at !== 3 || e !== 1'b0 || rd !== 32'h0) begin
        n_bad++; $display("FAIL clear_word%0d: ack_at %0d err %b data %h want 3 0 0", i, at, e, rd);
      end
    end
  endtask

  task automatic test_store_load();
    int ns, at; logic e; logic [31:0] rd;
    run_txn(1'b0, 1'b1, 32'h8, 32'hDEADBEEF, ns, at, e, rd);
    n_cmp++; if (ns !== 3) begin n_bad++; $display("FAIL store_stall_cycles: got %0d want 3", ns); end
    n_cmp++; if (at !== 3) begin n_bad++; $display("FAIL store_ack_cycle: got %0d want 3", at); end
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL store_err: got %b want 0", e); end
    run_txn(1'b1, 1'b0, 32'h8, 32'h0, ns, at, e, rd);
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL load_data: got %h want deadbeef", rd); end
    n_cmp++; if (ns !== 3 || at !== 3) begin n_bad++; $display("FAIL load_timing: stall %0d ack_at %0d want 3 3", ns, at); end
    run_txn(1'b0, 1'b1, 32'h14, 32'h11111111, ns, at, e, rd);
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL write_keeps_rdata: got %h want deadbeef", rd); end
  endtask

  task automatic test_faults();
    int ns, at; logic e; logic [31:0] rd;
    run_txn(1'b1, 1'b0, 32'h6, 32'h0, ns, at, e, rd);
    n_cmp++; if (ns !== 3 || at !== 3) begin n_bad++; $display("FAIL misalign_timing: stall %0d ack_at %0d want 3 3", ns, at); end
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL misalign_err: got %b want 1", e); end
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL misalign_rdata: got %h want 0", rd); end
    run_txn(1'b0, 1'b1, 32'h80, 32'hFFFFFFFF, ns, at, e, rd);
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL oob_store_err: got %b want 1", e); end
    run_txn(1'b0, 1'b1, 32'h2, 32'hAAAA5555, ns, at, e, rd);
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL misalign_store_err: got %b want 1", e); end
    run_txn(1'b1, 1'b0, 32'h0, 32'h0, ns, at, e, rd);
    n_cmp++; if (rd !== 32'h0 || e !== 1'b0) begin n_bad++; $display("FAIL fault_no_write_w0: data %h err %b want 0 0", rd, e); end
    run_txn(1'b1, 1'b0, 32'h8, 32'h0, ns, at, e, rd);
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL fault_keeps_w2: got %h want deadbeef", rd); end
  endtask

  task automatic test_rw_conflict();
    int ns, at; logic e; logic [31:0] rd;
    run_txn(1'b0, 1'b1, 32'h4, 32'h0BADF00D, ns, at, e, rd);
    run_txn(1'b1, 1'b1, 32'h4, 32'h00001234, ns, at, e, rd);
    n_cmp++; if (at !== 3 || e !== 1'b1) begin n_bad++; $display("FAIL rw_err: ack_at %0d err %b want 3 1", at, e); end
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL rw_rdata: got %h want 0", rd); end
    run_txn(1'b1, 1'b0, 32'h4, 32'h0, ns, at, e, rd);
    n_cmp++; if (rd !== 32'h0BADF00D) begin n_bad++; $display("FAIL rw_mem1_kept: got %h want 0badf00d", rd); end
  endtask

  task automatic test_wait_change();
    int ns, at; logic e; logic [31:0] rd;
    bus3.Memory_write_i = 1'b1;
    bus3.address_i      = 32'h4;
    bus3.write_data_i   = 32'hCAFE0001;
    tick();
    bus3.address_i      = 32'hC;
    bus3.write_data_i   = 32'h00000055;
    tick();
    tick();
    n_cmp++; if (bus3.ack_o !== 1'b1 || bus3.stall_o !== 1'b0) begin
      n_bad++; $display("FAIL wait_change_resp: ack %b stall %b want 1 0", bus3.ack_o, bus3.stall_o);
    end
    tick();
    clear3();
    #1;
    n_cmp++; if (bus3.stall_o !== 1'b0) begin n_bad++; $display("FAIL resp_no_restart_stall: got %b want 0", bus3.stall_o); end
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++; if (bus3.ack_o !== 1'b0) begin n_bad++; $display("FAIL resp_no_second_ack: got %b want 0", bus3.ack_o); end
    end
    run_txn(1'b1, 1'b0, 32'h4, 32'h0, ns, at, e, rd);
    n_cmp++; if (rd !== 32'hCAFE0001) begin n_bad++; $display("FAIL wait_change_w1: got %h want cafe0001", rd); end
    run_txn(1'b1, 1'b0, 32'hC, 32'h0, ns, at, e, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL wait_change_w3: got %h want 0", rd); end
  endtask

  task automatic test_reset_mid();
    int ns, at; logic e; logic [31:0] rd;
    bus3.Memory_write_i = 1'b1;
    bus3.address_i      = 32'h10;
    bus3.write_data_i   = 32'h00000077;
    tick();
    tick();
    rst_i = 1'b0;
    #1;
    n_cmp++; if (bus3.stall_o !== 1'b0 || bus3.ack_o !== 1'b0) begin
      n_bad++; $display("FAIL midreset_outputs: stall %b ack %b want 0 0", bus3.stall_o, bus3.ack_o);
    end
    clear3();
    #2 rst_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++; if (bus3.ack_o !== 1'b0) begin n_bad++; $display("FAIL midreset_no_ack: got %b want 0", bus3.ack_o); end
    end
    run_txn(1'b1, 1'b0, 32'h10, 32'h0, ns, at, e, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL midreset_w4: got %h want 0", rd); end
  endtask

  task automatic test_latency1();
    bus1.Memory_write_i = 1'b1;
    bus1.address_i      = 32'h8;
    bus1.write_data_i   = 32'h12345678;
    #1;
    n_cmp++; if (bus1.stall_o !== 1'b1 || bus1.ack_o !== 1'b0) begin
      n_bad++; $display("FAIL lat1_store_req: stall %b ack %b want 1 0", bus1.stall_o, bus1.ack_o);
    end
    tick();
    n_cmp++; if (bus1.ack_o !== 1'b1 || bus1.stall_o !== 1'b0 || bus1.err_o !== 1'b0) begin
      n_bad++; $display("FAIL lat1_store_ack: ack %b stall %b err %b want 1 0 0", bus1.ack_o, bus1.stall_o, bus1.err_o);
    end
    tick();
    bus1.Memory_write_i = 1'b0;
    bus1.Memory_read_i  = 1'b1;
    #1;
    n_cmp++; if (bus1.ack_o !== 1'b0 || bus1.stall_o !== 1'b1) begin
      n_bad++; $display("FAIL lat1_load_req: ack %b stall %b want 0 1", bus1.ack_o, bus1.stall_o);
    end
    tick();
    n_cmp++; if (bus1.ack_o !== 1'b1 || bus1.read_data_o !== 32'h12345678) begin
      n_bad++; $display("FAIL lat1_load_ack: ack %b data %h want 1 12345678", bus1.ack_o, bus1.read_data_o);
    end
    tick();
    bus1.Memory_read_i = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    clear3();
    test_reset();
    test_mem_clear();
    test_store_load();
    test_faults();
    test_rw_conflict();
    test_wait_change();
    test_reset_mid();
    test_latency1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder serving the MEM-stage load/store requests of the 5-stage pipeline.
- Accepts one read or write per transaction and holds the pipeline via stall_o until the access completes.
- Returns read data with a one-cycle ack_o pulse.
- Replaces the zero-latency data memory so that pipeline stall handling can be exercised against a realistic responder.

Parameters:
- DEPTH, 32, number of 32-bit words; power of two, >=2.
- LATENCY, 3, cycles from request acceptance to the ack_o cycle; >=1.

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- Memory_read_i  input  1  load request from the EX/MEM register.
- Memory_write_i  input  1  store request from the EX/MEM register.
- address_i  input  32  byte address (ALU result).
- write_data_i  input  32  store data.
- read_data_o  output  32  registered load data.
- ack_o  output  1  one-cycle completion pulse.
- stall_o  output  1  freeze PC and pipeline registers while high.
- err_o  output  1  one-cycle pulse alongside ack_o on a faulted request.

Behaviour:
- Interface: one clock (clk_i); reset rst_i is asynchronous and active-low.
- Reset (rst_i=0, immediate):
  - State goes to IDLE; counter to 0.
  - All DEPTH words clear to 0.
  - read_data_o=0, ack_o=0, err_o=0.
  - stall_o is forced to 0 while in reset.
- Request definition: req = Memory_read_i | Memory_write_i.
- State machine: IDLE, WAIT, RESP.
- IDLE:
  - stall_o = req (combinational, same cycle).
  - On a clock edge with req=1, capture address_i, write_data_i, the read/write type and the fault flag.
  - If LATENCY=1, go to RESP; otherwise go to WAIT with counter = LATENCY-2.
- WAIT:
  - stall_o=1.
  - Counter decrements each edge; at counter==0 go to RESP.
  - Inputs are ignored; captured values are used.
- Edge entering RESP:
  - Captured write, no fault: mem[index] <= captured data.
  - Captured read, no fault: read_data_o <= mem[index].
  - Fault: no memory change; read_data_o <= 0.
- RESP:
  - ack_o=1, stall_o=0, err_o=fault.
  - Inputs are ignored, since they still show the retiring request.
  - Next state is always IDLE.
- Timing: a request accepted at edge T0 sees ack_o high in the cycle after edge T0+LATENCY-1, i.e. LATENCY cycles after acceptance. stall_o is high for exactly LATENCY cycles per transaction.
- Back-to-back throughput: one transaction per LATENCY+1 cycles.
- Index: index = address_i[log2(DEPTH)+1:2].
- Fault, evaluated at capture. Any of:
  - address_i[1:0] != 0;
  - address_i >= 4*DEPTH;
  - Memory_read_i and Memory_write_i both 1.
- read_data_o holds its value until the next read ack or fault ack; a write ack does not change it.
- Reset mid-transaction (WAIT or RESP): transaction aborted, no write committed, no ack_o issued.

Test Plan:
- Reset then idle with no requests, LATENCY=3 → all outputs 0 and stall_o stays 0; memory reads back 0 everywhere.
- Store: address_i=0x8, write_data_i=0xDEADBEEF, Memory_write_i=1 → stall_o=1 for 3 cycles, ack_o pulses in the 4th cycle with err_o=0. A following load from 0x8 returns read_data_o=0xDEADBEEF on its ack.
- Misaligned load from 0x6 → stall_o for 3 cycles, ack_o=1 and err_o=1 together, read_data_o=0, memory unchanged. Store to 0x80 (DEPTH=32) → err_o=1, no word modified.
- Simultaneous Memory_read_i=Memory_write_i=1 at 0x4 with data 0x1234 → err_o=1 with ack_o; mem[1] remains at its prior value.
- Inputs changed during WAIT (address to 0xC, data to 0x55): the write still lands at the originally captured 0x4 with the original data. During the RESP cycle, held inputs do not start a second transaction.
- rst_i low during the second WAIT cycle of a store to 0x10 → immediate IDLE, no ack_o, mem[4]=0. With LATENCY=1, a store shows stall_o high for 1 cycle, then ack_o the next cycle.
